// File: rtl/datapath_pipe_if.sv
// Handshake bundle between control unit, memory port and the EX/WB datapath.
// The master side drives control words and load data; the slave side is the datapath.
interface datapath_pipe_if #(
  parameter int N    = 8,
  parameter int NREG = 4
);
  localparam int AW = $clog2(NREG);
  localparam int CW = 3*AW + 10;

  logic [CW-1:0] ctrl_word;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  data_in;
  logic          data_in_valid;
  logic          data_in_ready;
  logic [N-1:0]  constant_in;
  logic [N-1:0]  address_out;
  logic [N-1:0]  data_out;
  logic [N-1:0]  result;
  logic          result_valid;
  logic [3:0]    state_bits;

  modport master (
    output ctrl_word, in_valid, data_in,
    output data_in_valid, constant_in,
    input  in_ready, data_in_ready,
    input  address_out, data_out,
    input  result, result_valid, state_bits
  );

  modport slave (
    input  ctrl_word, in_valid, data_in,
    input  data_in_valid, constant_in,
    output in_ready, data_in_ready,
    output address_out, data_out,
    output result, result_valid, state_bits
  );
endinterface

// File: rtl/datapath_pipe.sv
// 2-stage EX/WB datapath: register file, ALU with carry-in, 1-bit shifter, load path.
// Define DATAPATH_FWD_EN to forward WB data into EX instead of stalling one cycle.
module datapath_pipe #(
  parameter int N    = 8,
  parameter int NREG = 4
) (
  input logic            clk,
  input logic            rst_n,
  datapath_pipe_if.slave bus
);
  localparam int AW = $clog2(NREG);

  typedef struct packed {
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] d;
    logic          we;
    logic          mb;
    logic [3:0]    g;
    logic [1:0]    h;
    logic          mf;
    logic          md;
  } ctrl_t;

  typedef struct packed {
    logic          v;
    logic          we;
    logic [AW-1:0] d;
    logic [N-1:0]  f;
  } wb_t;

  ctrl_t        c;
  wb_t          wb;
  logic [N-1:0] rf [NREG];

  logic         fwd_a, fwd_b, hazard, accept;
  logic [N-1:0] ra, rb, y;
  logic [N-1:0] addb, alu, shf, f1, f;
  logic [N:0]   sum;
  logic [2:0]   op;
  logic         arith, cf, vf;

  assign c  = ctrl_t'(bus.ctrl_word);
  assign op = c.g[3:1];

  assign fwd_a = wb.v & wb.we & (wb.d == c.a);
  assign fwd_b = wb.v & wb.we & (wb.d == c.b);

`ifdef DATAPATH_FWD_EN
  assign ra     = fwd_a ? wb.f : rf[c.a];
  assign rb     = fwd_b ? wb.f : rf[c.b];
  assign hazard = 1'b0;
`else
  assign ra     = rf[c.a];
  assign rb     = rf[c.b];
  assign hazard = fwd_a | (c.mb & fwd_b);
`endif

  assign y = c.mb ? rb : bus.constant_in;

  assign bus.in_ready      = ~(c.md & ~bus.data_in_valid) & ~hazard;
  assign accept            = bus.in_valid & bus.in_ready;
  assign bus.data_in_ready = accept & c.md;
  assign bus.address_out   = ra;
  assign bus.data_out      = y;

  always_comb begin
    addb = '0;
    alu  = '0;
    case (op)
      3'b001:  addb = y;
      3'b010:  addb = ~y;
      default: addb = '0;
    endcase
    sum   = {1'b0, ra} + {1'b0, addb} + {{N{1'b0}}, c.g[0]};
    arith = (op == 3'b000) | (op == 3'b001) | (op == 3'b010);
    cf    = arith & sum[N];
    // overflow: both addends share a sign that the sum does not
    vf    = arith & (ra[N-1] == addb[N-1]) & (sum[N-1] != ra[N-1]);
    case (op)
      3'b011:  alu = ra & y;
      3'b100:  alu = ra | y;
      3'b101:  alu = ra ^ y;
      3'b110:  alu = ~ra;
      3'b111:  alu = y;
      default: alu = sum[N-1:0];
    endcase
  end

  always_comb begin
    shf = y;
    unique case (1'b1)
      c.h == 2'b01: shf = {y[N-2:0], 1'b0};
      c.h == 2'b10: shf = {1'b0, y[N-1:1]};
      c.h == 2'b11: shf = {y[0], y[N-1:1]};
      default:      shf = y;
    endcase
  end

  assign f1 = c.mf ? shf : alu;
  assign f  = c.md ? bus.data_in : f1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.result       <= '0;
      bus.result_valid <= 1'b0;
      bus.state_bits   <= '0;
      wb               <= '0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      bus.result_valid <= accept;
      wb.v             <= accept;
      if (accept) begin
        bus.result <= f;
        wb.we      <= c.we;
        wb.d       <= c.d;
        wb.f       <= f;
        if (!c.mf && !c.md)
          bus.state_bits <= {f == '0, f[N-1], cf, vf};
      end
      if (wb.v && wb.we) rf[wb.d] <= wb.f;
    end
  end
endmodule

// File: tb/tb_datapath_pipe.sv
// Directed-vector bench for datapath_pipe (N=8, NREG=4).
// Inputs change 1 time unit after posedge; outputs are sampled there too.
module tb_datapath_pipe;
  localparam int N    = 8;
  localparam int NREG = 4;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  datapath_pipe_if #(.N(N), .NREG(NREG)) bus ();

  datapath_pipe #(.N(N), .NREG(NREG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mk(
    input logic [1:0] a, input logic [1:0] b,
    input logic [1:0] d, input logic we,
    input logic mb, input logic [3:0] g,
    input logic [1:0] h, input logic mf,
    input logic md);
    return {a, b, d, we, mb, g, h, mf, md};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid      = 1'b0;
    bus.data_in_valid = 1'b0;
    bus.ctrl_word     = '0;
    cyc();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    idle();
    tests++;
    if (bus.result !== 8'h00 || bus.result_valid !== 1'b0 ||
        bus.state_bits !== 4'h0) begin
      fails++;
      $display("FAIL reset_state: res=%h rv=%b sb=%b want 00/0/0000",
               bus.result, bus.result_valid, bus.state_bits);
    end
    rst_n = 1'b1;
    bus.ctrl_word = mk(2'd0, 2'd0, 2'd0, 1'b0, 1'b1,
                       4'b0101, 2'b00, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    cyc();
    tests++;
    if (bus.state_bits !== 4'b1010) begin
      fails++;
      $display("FAIL reset_presub_flags: got %b want 1010", bus.state_bits);
    end
    bus.ctrl_word = mk(2'd0, 2'd0, 2'd2, 1'b1, 1'b0,
                       4'b0000, 2'b00, 1'b0, 1'b1);
    bus.data_in = 8'h33;
    bus.data_in_valid = 1'b1;
    cyc();
    tests++;
    if (bus.result !== 8'h33) begin
      fails++;
      $display("FAIL reset_preload: got %h want 33", bus.result);
    end
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    tests++;
    if (bus.result !== 8'h00 || bus.result_valid !== 1'b0 ||
        bus.state_bits !== 4'h0) begin
      fails++;
      $display("FAIL reset_mid: res=%h rv=%b sb=%b want 00/0/0000",
               bus.result, bus.result_valid, bus.state_bits);
    end
    cyc();
    rst_n = 1'b1;
    bus.data_in_valid = 1'b0;
    bus.ctrl_word = mk(2'd2, 2'd0, 2'd0, 1'b0, 1'b0,
                       4'b0000, 2'b00, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.address_out !== 8'h00) begin
      fails++;
      $display("FAIL reset_release: rdy=%b r2=%h want 1/00",
               bus.in_ready, bus.address_out);
    end
    cyc();
    tests++;
    if (bus.result !== 8'h00 || bus.state_bits !== 4'b1000) begin
      fails++;
      $display("FAIL reset_lost_write: res=%h sb=%b want 00/1000",
               bus.result, bus.state_bits);
    end
  endtask

  task automatic test_load();
    idle();
    bus.ctrl_word = mk(2'd0, 2'd0, 2'd1, 1'b1, 1'b0,
                       4'b0000, 2'b00, 1'b0, 1'b1);
    bus.data_in = 8'h5A;
    bus.data_in_valid = 1'b1;
    bus.in_valid = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.data_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL load_hs: rdy=%b drdy=%b want 1/1",
               bus.in_ready, bus.data_in_ready);
    end
    cyc();
    tests++;
    if (bus.result !== 8'h5A || bus.result_valid !== 1'b1 ||
        bus.state_bits !== 4'b1000) begin
      fails++;
      $display("FAIL load_result: res=%h rv=%b sb=%b want 5a/1/1000",
               bus.result, bus.result_valid, bus.state_bits);
    end
    idle();
    tests++;
    if (bus.result_valid !== 1'b0) begin
      fails++;
      $display("FAIL load_idle_rv: got %b want 0", bus.result_valid);
    end
    bus.ctrl_word = mk(2'd1, 2'd0, 2'd0, 1'b0, 1'b0,
                       4'b0000, 2'b00, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    #1;
    tests++;
    if (bus.address_out !== 8'h5A) begin
      fails++;
      $display("FAIL load_readback: got %h want 5a", bus.address_out);
    end
    cyc();
    tests++;
    if (bus.result !== 8'h5A || bus.state_bits !== 4'b0000) begin
      fails++;
      $display("FAIL load_pass: res=%h sb=%b want 5a/0000",
               bus.result, bus.state_bits);
    end
  endtask

  task automatic test_raw();
    int stalls;
    int exp_stalls;
`ifdef DATAPATH_FWD_EN
    exp_stalls = 0;
`else
    exp_stalls = 1;
`endif
    idle();
    bus.ctrl_word = mk(2'd0, 2'd0, 2'd1, 1'b1, 1'b0,
                       4'b0000, 2'b00, 1'b0, 1'b1);
    bus.data_in = 8'h7F;
    bus.data_in_valid = 1'b1;
    bus.in_valid = 1'b1;
    cyc();
    bus.ctrl_word = mk(2'd0, 2'd0, 2'd2, 1'b1, 1'b0,
                       4'b0000, 2'b00, 1'b0, 1'b1);
    bus.data_in = 8'h01;
    cyc();
    idle();
    bus.ctrl_word = mk(2'd1, 2'd2, 2'd3, 1'b1, 1'b1,
                       4'b0010, 2'b00, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL raw_first_ready: got %b want 1", bus.in_ready);
    end
    cyc();
    tests++;
    if (bus.result !== 8'h80 || bus.state_bits !== 4'b0101) begin
      fails++;
      $display("FAIL raw_add1: res=%h sb=%b want 80/0101",
               bus.result, bus.state_bits);
    end
    bus.ctrl_word = mk(2'd3, 2'd3, 2'd0, 1'b1, 1'b1,
                       4'b0010, 2'b00, 1'b0, 1'b0);
    stalls = 0;
    #1;
    while (bus.in_ready !== 1'b1 && stalls < 4) begin
      stalls++;
      cyc();
      #1;
    end
    tests++;
    if (stalls !== exp_stalls) begin
      fails++;
      $display("FAIL raw_stalls: got %0d want %0d", stalls, exp_stalls);
    end
    cyc();
    tests++;
    if (bus.result !== 8'h00 || bus.state_bits !== 4'b1011) begin
      fails++;
      $display("FAIL raw_add2: res=%h sb=%b want 00/1011",
               bus.result, bus.state_bits);
    end
  endtask

  task automatic test_data_stall();
    idle();
    bus.ctrl_word = mk(2'd0, 2'd0, 2'd2, 1'b1, 1'b0,
                       4'b0000, 2'b00, 1'b0, 1'b1);
    bus.data_in = 8'h77;
    bus.data_in_valid = 1'b0;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (bus.in_ready !== 1'b0 || bus.data_in_ready !== 1'b0) begin
        fails++;
        $display("FAIL dstall_hold%0d: rdy=%b drdy=%b want 0/0",
                 i, bus.in_ready, bus.data_in_ready);
      end
      cyc();
      tests++;
      if (bus.result_valid !== 1'b0) begin
        fails++;
        $display("FAIL dstall_rv%0d: got %b want 0", i, bus.result_valid);
      end
    end
    bus.data_in_valid = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1 || bus.data_in_ready !== 1'b1) begin
      fails++;
      $display("FAIL dstall_go: rdy=%b drdy=%b want 1/1",
               bus.in_ready, bus.data_in_ready);
    end
    cyc();
    tests++;
    if (bus.result !== 8'h77 || bus.result_valid !== 1'b1) begin
      fails++;
      $display("FAIL dstall_result: res=%h rv=%b want 77/1",
               bus.result, bus.result_valid);
    end
  endtask

  task automatic test_shift();
    logic [1:0] hs [3];
    logic [7:0] ex [3];
    hs[0] = 2'b11; ex[0] = 8'hC0;
    hs[1] = 2'b01; ex[1] = 8'h02;
    hs[2] = 2'b10; ex[2] = 8'h40;
    idle();
    bus.constant_in = 8'h81;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.ctrl_word = mk(2'd0, 2'd0, 2'd0, 1'b0, 1'b0,
                         4'b0000, hs[i], 1'b1, 1'b0);
      cyc();
      tests++;
      if (bus.result !== ex[i] || bus.state_bits !== 4'b1011) begin
        fails++;
        $display("FAIL shift_h%b: res=%h sb=%b want %h/1011",
                 hs[i], bus.result, bus.state_bits, ex[i]);
      end
    end
  endtask

  task automatic test_logic_ops();
    logic [3:0] gs [6];
    logic [7:0] ex [6];
    logic [3:0] fl [6];
    gs[0] = 4'b0110; ex[0] = 8'h0C; fl[0] = 4'b0000;
    gs[1] = 4'b1000; ex[1] = 8'h3F; fl[1] = 4'b0000;
    gs[2] = 4'b1010; ex[2] = 8'h33; fl[2] = 4'b0000;
    gs[3] = 4'b1100; ex[3] = 8'hC3; fl[3] = 4'b0100;
    gs[4] = 4'b1110; ex[4] = 8'h0F; fl[4] = 4'b0000;
    gs[5] = 4'b0001; ex[5] = 8'h3D; fl[5] = 4'b0000;
    idle();
    bus.ctrl_word = mk(2'd0, 2'd0, 2'd1, 1'b1, 1'b0,
                       4'b0000, 2'b00, 1'b0, 1'b1);
    bus.data_in = 8'h3C;
    bus.data_in_valid = 1'b1;
    bus.in_valid = 1'b1;
    cyc();
    idle();
    bus.constant_in = 8'h0F;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus.ctrl_word = mk(2'd1, 2'd0, 2'd0, 1'b0, 1'b0,
                         gs[i], 2'b00, 1'b0, 1'b0);
      cyc();
      tests++;
      if (bus.result !== ex[i] || bus.state_bits !== fl[i]) begin
        fails++;
        $display("FAIL alu_g%b: res=%h sb=%b want %h/%b",
                 gs[i], bus.result, bus.state_bits, ex[i], fl[i]);
      end
    end
  endtask

  task automatic test_sub();
    idle();
    bus.ctrl_word = mk(2'd0, 2'd0, 2'd1, 1'b1, 1'b0,
                       4'b0000, 2'b00, 1'b0, 1'b1);
    bus.data_in = 8'h05;
    bus.data_in_valid = 1'b1;
    bus.in_valid = 1'b1;
    cyc();
    idle();
    bus.ctrl_word = mk(2'd1, 2'd0, 2'd0, 1'b0, 1'b0,
                       4'b0101, 2'b00, 1'b0, 1'b0);
    bus.constant_in = 8'h05;
    bus.in_valid = 1'b1;
    #1;
    tests++;
    if (bus.address_out !== 8'h05 || bus.data_out !== 8'h05) begin
      fails++;
      $display("FAIL sub_operands: a=%h d=%h want 05/05",
               bus.address_out, bus.data_out);
    end
    cyc();
    tests++;
    if (bus.result !== 8'h00 || bus.state_bits !== 4'b1010) begin
      fails++;
      $display("FAIL sub_result: res=%h sb=%b want 00/1010",
               bus.result, bus.state_bits);
    end
    bus.in_valid = 1'b0;
    bus.ctrl_word = mk(2'd1, 2'd0, 2'd0, 1'b0, 1'b0,
                       4'b0010, 2'b00, 1'b0, 1'b0);
    bus.constant_in = 8'h7F;
    cyc();
    tests++;
    if (bus.result_valid !== 1'b0 || bus.result !== 8'h00 ||
        bus.state_bits !== 4'b1010) begin
      fails++;
      $display("FAIL sub_novalid: rv=%b res=%h sb=%b want 0/00/1010",
               bus.result_valid, bus.result, bus.state_bits);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    bus.ctrl_word = '0;
    bus.in_valid = 1'b0;
    bus.data_in = '0;
    bus.data_in_valid = 1'b0;
    bus.constant_in = '0;
    #1;
    test_reset();
    test_load();
    test_raw();
    test_data_stall();
    test_shift();
    test_logic_ops();
    test_sub();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
